mem_store_buffer: RTL and testbench
===================================

Name: mem_store_buffer

Overview:
- Store buffer placed between the EX/MEM pipeline register and the data memory (dm_8k).
- Stores are queued in a FIFO and written to memory one per cycle, whenever the memory port is not needed by a load.
- Loads pass straight through to memory.
- A load whose word address matches any pending store stalls the pipeline until that store has drained.

Parameters:
- DEPTH, 4, number of store entries (power of two).
- PTR_W, 2, log2(DEPTH); width of the head and tail pointers.
- NONE/WORD/HALF/BYTE, 2'b00/2'b01/2'b10/2'b11, LS_bit encodings; identical to dm_8k.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX/MEM holds a valid memory op this cycle.
- in_MemWrite  in  1  1 = store, 0 = load.
- in_LS_bit  in  2  access size (NONE/WORD/HALF/BYTE).
- in_Ext_op  in  1  load sign-extend select; passed through to memory.
- in_addr  in  32  byte address (EX_MEM_mux5_out).
- in_wdata  in  32  store data (EX_MEM_mux3_out).
- stall  out  1  hold EX/MEM and upstream stages; inputs stay stable while high.
- dm_MemWrite  out  1  drives dm EX_MEM_MemWrite.
- dm_LS_bit  out  2  drives dm EX_MEM_LS_bit.
- dm_Ext_op  out  1  drives dm EX_MEM_Ext_op.
- dm_addr  out  32  drives dm EX_MEM_mux5_out.
- dm_wdata  out  32  drives dm EX_MEM_mux3_out.
- empty  out  1  no pending stores.
- count  out  PTR_W+1  number of pending stores.

Behaviour:
- Storage: DEPTH entries, each holding {LS_bit, addr[31:0], wdata[31:0]}. Also a head pointer, a tail pointer and a count register. Pointers wrap modulo DEPTH.
- Reset (async): head=tail=0, count=0. Entry contents are don't-care. Consequently empty=1, stall=0, dm_MemWrite=0, dm_LS_bit=NONE, dm_addr=0, dm_wdata=0, dm_Ext_op=0.
- Decode:
  - is_st = in_valid & in_MemWrite & (in_LS_bit != NONE).
  - is_ld = in_valid & ~in_MemWrite & (in_LS_bit != NONE).
- Conflict: is_ld, and some valid entry satisfies entry.addr[11:2] == in_addr[11:2]. The comparison is word-granular regardless of size, matching the dm index.
- full = (count == DEPTH).
- stall = (is_st & full) | (is_ld & conflict). Purely combinational.
- Port arbitration, evaluated each cycle (memory-side outputs are combinational):
  - Load pass: is_ld & ~conflict. Drive dm_MemWrite=0, dm_LS_bit=in_LS_bit, dm_addr=in_addr, dm_Ext_op=in_Ext_op, dm_wdata=0. No drain this cycle.
  - Drain: otherwise, if count>0. Drive dm_MemWrite=1 and dm_LS_bit/addr/wdata from the head entry, dm_Ext_op=0. At the rising edge: head+1, pop.
  - Idle: otherwise. dm_MemWrite=0, dm_LS_bit=NONE, addr=0, wdata=0.
- Push: at the rising edge when is_st & ~full, write the entry at tail, then tail+1.
- Latency: an accepted store reaches memory no earlier than the cycle after its push. A store never bypasses the buffer straight to memory.
- Count update:
  - push & pop: count unchanged.
  - push only: count+1.
  - pop only: count-1.
- Full with a store: stall=1 and no push. The head drains in the same cycle (no load is present), so the held store is accepted on the following cycle.
- Conflicting load:
  - The memory port drains instead of serving the load.
  - stall remains high until no matching entry is left. The load then passes through in the first cycle where the conflict is clear.
  - Ordering guarantees the load observes all older stores to that word.
- Drain order is strict FIFO, so two stores to the same word apply in program order.
- Ops with LS_bit == NONE, or in_valid=0, are ignored and never stall.
- Reset asserted mid-drain or mid-stall: all pending stores are discarded and outputs immediately take their reset values.

Test Plan:
- Reset, then idle → empty=1, count=0, stall=0, dm_LS_bit=NONE, dm_MemWrite=0.
- SW 0x11223344 @0x10, then idle → count=1 after edge 1. Next cycle: dm_MemWrite=1, dm_addr=0x10, dm_wdata=0x11223344, dm_LS_bit=WORD. count=0 after that edge.
- SB 0xAA @0x21, then LB @0x22 on the next cycle → conflict (word 8): stall=1 for 1 cycle while the SB drains. Then the load passes with dm_addr=0x22, dm_MemWrite=0, stall=0.
- 4 back-to-back loads at 0x100–0x10C while 2 stores (@0x0, @0x4) are pending → all loads pass with no stall. count stays 2, then drains to 0 during the following two idle cycles.
- 5 consecutive SWs (@0x0..0x10) with loads to 0x200 interleaved so no drain occurs → 5th SW sees full=1 and stall=1. On the first non-load cycle the head drains and the 5th SW is pushed. Drain order is addr 0x0,0x4,0x8,0xC,0x10.
- 3 stores pending, then reset pulse → count=0, empty=1, dm_MemWrite=0 immediately. No pending store is written afterwards.

Source files
------------

// File: rtl/mem_store_buffer.sv
// Store buffer between the EX/MEM register and the data memory.
// Stores are queued and written back one per cycle whenever the memory
// port is not serving a load; loads go straight to memory unless they hit
// a pending store's word, in which case the pipeline is held until it drains.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_MemWrite,
  input  logic [1:0]       in_LS_bit,
  input  logic             in_Ext_op,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_wdata,
  output logic             stall,
  output logic             dm_MemWrite,
  output logic [1:0]       dm_LS_bit,
  output logic             dm_Ext_op,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [1:0] NONE = 2'b00;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Entry storage; contents are meaningful only between head and tail
  logic [1:0]       ent_ls    [DEPTH];
  logic [31:0]      ent_addr  [DEPTH];
  logic [31:0]      ent_wdata [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count_r;

  logic is_st;
  logic is_ld;
  logic full;
  logic conflict;
  logic load_pass;
  logic push;
  logic pop;

  assign is_st     = in_valid &  in_MemWrite & (in_LS_bit != NONE);
  assign is_ld     = in_valid & ~in_MemWrite & (in_LS_bit != NONE);
  assign full      = (count_r == FULL_CNT);
  assign load_pass = is_ld & ~conflict;
  assign pop       = ~load_pass & (count_r != '0);
  assign push      = is_st & ~full;
  assign stall     = (is_st & full) | (is_ld & conflict);
  assign empty     = (count_r == '0);
  assign count     = count_r;

  // Word-granular match of the load address against every live entry
  always_comb begin
    logic [PTR_W-1:0] off;
    off      = '0;
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - head;
      if (({1'b0, off} < count_r) && (ent_addr[i][11:2] == in_addr[11:2]))
        conflict = is_ld;
    end
  end

  // Memory port: load pass-through has priority, else drain the head
  always_comb begin
    dm_MemWrite = 1'b0;
    dm_LS_bit   = NONE;
    dm_Ext_op   = 1'b0;
    dm_addr     = '0;
    dm_wdata    = '0;
    if (load_pass) begin
      dm_LS_bit = in_LS_bit;
      dm_Ext_op = in_Ext_op;
      dm_addr   = in_addr;
    end else if (pop) begin
      dm_MemWrite = 1'b1;
      dm_LS_bit   = ent_ls[head];
      dm_addr     = ent_addr[head];
      dm_wdata    = ent_wdata[head];
    end
  end

  // Entry write on push; data is not reset
  always_ff @(posedge clock) begin
    if (push) begin
      ent_ls[tail]    <= in_LS_bit;
      ent_addr[tail]  <= in_addr;
      ent_wdata[tail] <= in_wdata;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench for mem_store_buffer: directed vector table,
// an asynchronous reset sequence, and randomized traffic against a
// queue-based reference model.
module tb_mem_store_buffer;

  localparam logic [1:0] NONE = 2'b00, WORD = 2'b01, HALF = 2'b10, BYTE = 2'b11;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_MemWrite, in_Ext_op;
  logic [1:0]  in_LS_bit;
  logic [31:0] in_addr, in_wdata;
  logic        stall, dm_MemWrite, dm_Ext_op, empty;
  logic [1:0]  dm_LS_bit;
  logic [31:0] dm_addr, dm_wdata;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  mem_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_MemWrite(in_MemWrite), .in_LS_bit(in_LS_bit),
    .in_Ext_op(in_Ext_op), .in_addr(in_addr), .in_wdata(in_wdata),
    .stall(stall), .dm_MemWrite(dm_MemWrite), .dm_LS_bit(dm_LS_bit),
    .dm_Ext_op(dm_Ext_op), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .empty(empty), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic v, mw; logic [1:0] ls; logic ext; logic [31:0] a, d;
    logic e_stall, e_mw; logic [1:0] e_ls; logic e_ext;
    logic [31:0] e_a, e_d; int e_cnt;
  } vec_t;

  typedef struct { logic [1:0] ls; logic [31:0] a, d; } ent_t;

  function automatic vec_t mk(input logic v, mw, input logic [1:0] ls, input logic ext,
                              input logic [31:0] a, d, input logic es, emw,
                              input logic [1:0] els, input logic eext,
                              input logic [31:0] ea, ed, input int ec);
    vec_t t;
    t.v = v; t.mw = mw; t.ls = ls; t.ext = ext; t.a = a; t.d = d;
    t.e_stall = es; t.e_mw = emw; t.e_ls = els; t.e_ext = eext;
    t.e_a = ea; t.e_d = ed; t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, mw, input logic [1:0] ls, input logic ext,
                       input logic [31:0] a, d);
    in_valid = v; in_MemWrite = mw; in_LS_bit = ls; in_Ext_op = ext;
    in_addr = a; in_wdata = d;
  endtask

  task automatic chk_outs(input string tag, input logic es, emw, input logic [1:0] els,
                          input logic eext, input logic [31:0] ea, ed, input int ec);
    chk({tag, ".stall"},  32'(stall), 32'(es));
    chk({tag, ".dm_mw"},  32'(dm_MemWrite), 32'(emw));
    chk({tag, ".dm_ls"},  32'(dm_LS_bit), 32'(els));
    chk({tag, ".dm_ext"}, 32'(dm_Ext_op), 32'(eext));
    chk({tag, ".dm_addr"}, dm_addr, ea);
    chk({tag, ".dm_wdata"}, dm_wdata, ed);
    chk({tag, ".count"},  32'(count), 32'(ec));
    chk({tag, ".empty"},  32'(empty), 32'(ec == 0));
  endtask

  vec_t tbl[17];
  ent_t q[$];

  initial begin
    drive(1'b0, 1'b0, NONE, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;

    tbl[0]  = mk(0,0,NONE,0,32'h0,32'h0,          0,0,NONE,0,32'h0,32'h0,0);
    tbl[1]  = mk(1,1,WORD,0,32'h10,32'h11223344,  0,0,NONE,0,32'h0,32'h0,0);
    tbl[2]  = mk(0,0,NONE,0,32'h0,32'h0,          0,1,WORD,0,32'h10,32'h11223344,1);
    tbl[3]  = mk(1,1,BYTE,0,32'h21,32'hAA,        0,0,NONE,0,32'h0,32'h0,0);
    tbl[4]  = mk(1,0,BYTE,1,32'h22,32'h0,         1,1,BYTE,0,32'h21,32'hAA,1);
    tbl[5]  = mk(1,0,BYTE,1,32'h22,32'h0,         0,0,BYTE,1,32'h22,32'h0,0);
    tbl[6]  = mk(1,1,WORD,0,32'h0,32'h1,          0,0,NONE,0,32'h0,32'h0,0);
    tbl[7]  = mk(1,0,WORD,0,32'h100,32'h0,        0,0,WORD,0,32'h100,32'h0,1);
    tbl[8]  = mk(1,0,WORD,0,32'h104,32'h0,        0,0,WORD,0,32'h104,32'h0,1);
    tbl[9]  = mk(0,0,NONE,0,32'h0,32'h0,          0,1,WORD,0,32'h0,32'h1,1);
    tbl[10] = mk(0,0,NONE,0,32'h0,32'h0,          0,0,NONE,0,32'h0,32'h0,0);
    tbl[11] = mk(1,1,HALF,0,32'h8,32'hBEEF,       0,0,NONE,0,32'h0,32'h0,0);
    tbl[12] = mk(1,1,WORD,0,32'hC,32'h5,          0,1,HALF,0,32'h8,32'hBEEF,1);
    tbl[13] = mk(1,0,WORD,1,32'h100C,32'h0,       1,1,WORD,0,32'hC,32'h5,1);
    tbl[14] = mk(1,0,WORD,1,32'h100C,32'h0,       0,0,WORD,1,32'h100C,32'h0,0);
    tbl[15] = mk(1,1,NONE,0,32'h40,32'h7,         0,0,NONE,0,32'h0,32'h0,0);
    tbl[16] = mk(0,1,WORD,0,32'h44,32'h9,         0,0,NONE,0,32'h0,32'h0,0);

    // Reset state
    #12;
    chk_outs("reset", 0, 0, NONE, 0, 32'h0, 32'h0, 0);
    @(negedge clock);
    reset = 1'b0;

    // Directed vectors, each evaluated just before the rising edge
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v, tbl[i].mw, tbl[i].ls, tbl[i].ext, tbl[i].a, tbl[i].d);
      #1;
      chk_outs($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_mw, tbl[i].e_ls,
               tbl[i].e_ext, tbl[i].e_a, tbl[i].e_d, tbl[i].e_cnt);
      @(posedge clock);
      @(negedge clock);
    end

    // Asynchronous reset with a store pending
    drive(1, 1, WORD, 0, 32'h50, 32'h77);
    @(posedge clock);
    @(negedge clock);
    drive(0, 0, NONE, 0, 32'h0, 32'h0);
    #1;
    chk("pre_reset.count", 32'(count), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk_outs("async_reset", 0, 0, NONE, 0, 32'h0, 32'h0, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_outs("post_reset", 0, 0, NONE, 0, 32'h0, 32'h0, 0);
    @(posedge clock);
    @(negedge clock);
    #1;
    chk_outs("post_reset2", 0, 0, NONE, 0, 32'h0, 32'h0, 0);
    @(negedge clock);

    // Randomized traffic against the queue model
    begin
      logic held;
      held = 1'b0;
      q.delete();
      for (int n = 0; n < 600; n++) begin
        logic is_st, is_ld, conf, full, es, emw, eext, pass, drain;
        logic [1:0] els;
        logic [31:0] ea, ed;
        int r;
        if (!held) begin
          r = $urandom_range(0, 9);
          drive(r < 8, r < 4, 2'($urandom_range(0, 3)), 1'($urandom),
                ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 31)), $urandom);
        end
        is_st = in_valid & in_MemWrite & (in_LS_bit != NONE);
        is_ld = in_valid & ~in_MemWrite & (in_LS_bit != NONE);
        conf = 1'b0;
        foreach (q[k]) if (q[k].a[11:2] == in_addr[11:2]) conf = is_ld;
        full  = (q.size() == 4);
        es    = (is_st & full) | (is_ld & conf);
        pass  = is_ld & ~conf;
        drain = ~pass & (q.size() > 0);
        emw = 0; els = NONE; eext = 0; ea = 0; ed = 0;
        if (pass) begin
          els = in_LS_bit; eext = in_Ext_op; ea = in_addr;
        end else if (drain) begin
          emw = 1; els = q[0].ls; ea = q[0].a; ed = q[0].d;
        end
        #1;
        chk_outs($sformatf("rnd%0d", n), es, emw, els, eext, ea, ed, q.size());
        @(posedge clock);
        if (drain) void'(q.pop_front());
        if (is_st & ~full) q.push_back('{ls: in_LS_bit, a: in_addr, d: in_wdata});
        held = es;
        @(negedge clock);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
